// File: rtl/clock_disp_pkg.sv
// Shared constants, state encoding and anode helper for the clock display scanner.
// The leading-zero blanking option (LEADING_ZERO_BLANK_EN) is resolved in the top module.
package clock_disp_pkg;

    localparam int NUM_DIGITS = 6;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // Active-low segment patterns, g..a on [6:0]
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low one-hot anode select for digit i
    function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [2:0] i);
        logic [NUM_DIGITS-1:0] oh;
        oh    = '0;
        oh[i] = 1'b1;
        return ~oh;
    endfunction

endpackage

// File: rtl/clock_display_scanner_seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD nibbles render blank.
module seg7_decode
    import clock_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_BLANK;
        case (bcd)
            4'd0:    seg_n = SEG_0;
            4'd1:    seg_n = SEG_1;
            4'd2:    seg_n = SEG_2;
            4'd3:    seg_n = SEG_3;
            4'd4:    seg_n = SEG_4;
            4'd5:    seg_n = SEG_5;
            4'd6:    seg_n = SEG_6;
            4'd7:    seg_n = SEG_7;
            4'd8:    seg_n = SEG_8;
            4'd9:    seg_n = SEG_9;
            default: seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/clock_display_scanner.sv
// Six-digit multiplexed 7-segment scanner with dead-time gaps and per-frame input snapshot.
// Define LEADING_ZERO_BLANK_EN to blank a zero hour-tens digit.
module clock_display_scanner
    import clock_disp_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] digits_in,
    input  logic [5:0]  dp_in,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [5:0]  an_n,
    output logic        frame_tick
);

    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [2:0]       LAST_IDX   = 3'(NUM_DIGITS - 1);
    localparam bit               HAS_GAP    = (BLANK_CYCLES > 0);

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZ_BLANK = 1'b1;
`else
    localparam bit LZ_BLANK = 1'b0;
`endif

    state_t                      state, state_nxt;
    logic [2:0]                  idx, idx_nxt;
    logic [CNT_W-1:0]            cnt, cnt_nxt;
    logic [NUM_DIGITS-1:0][3:0]  snap, snap_nxt;
    logic [NUM_DIGITS-1:0]       dp_snap, dp_snap_nxt;
    logic [NUM_DIGITS-1:0][6:0]  dec_seg;
    logic                        capture;

    logic [5:0] an_nxt;
    logic [6:0] seg_nxt;
    logic       dp_nxt;
    logic       tick_nxt;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt + CNT_ONE;
        case (state)
            ST_BLANK: begin
                if (!HAS_GAP || cnt == BLANK_LAST) begin
                    state_nxt = ST_SHOW;
                    cnt_nxt   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt == SHOW_LAST) begin
                    idx_nxt   = (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
                    state_nxt = HAS_GAP ? ST_BLANK : ST_SHOW;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_BLANK;
                idx_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Latch a fresh frame only on the edge that first lights digit 0
    always_comb begin
        capture     = (state_nxt == ST_SHOW) && (idx_nxt == 3'd0) &&
                      !((state == ST_SHOW) && (idx == 3'd0));
        snap_nxt    = capture ? digits_in : snap;
        dp_snap_nxt = capture ? dp_in : dp_snap;
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dec
        seg7_decode u_dec (
            .bcd   (snap_nxt[k]),
            .seg_n (dec_seg[k])
        );
    end

    // Outputs derived from next-state so the registered pins line up with the state register
    always_comb begin
        an_nxt   = 6'h3F;
        seg_nxt  = SEG_BLANK;
        dp_nxt   = 1'b1;
        tick_nxt = 1'b0;
        if (state_nxt == ST_SHOW) begin
            an_nxt   = anode_sel(idx_nxt);
            seg_nxt  = dec_seg[idx_nxt];
            dp_nxt   = ~dp_snap_nxt[idx_nxt];
            tick_nxt = (idx_nxt == LAST_IDX) && (cnt_nxt == SHOW_LAST);
            if (LZ_BLANK && idx_nxt == LAST_IDX && snap_nxt[NUM_DIGITS-1] == 4'd0)
                seg_nxt = SEG_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_BLANK;
            idx        <= '0;
            cnt        <= '0;
            snap       <= '0;
            dp_snap    <= '0;
            an_n       <= 6'h3F;
            seg_n      <= SEG_BLANK;
            dp_n       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            snap       <= snap_nxt;
            dp_snap    <= dp_snap_nxt;
            an_n       <= an_nxt;
            seg_n      <= seg_nxt;
            dp_n       <= dp_nxt;
            frame_tick <= tick_nxt;
        end
    end

endmodule

// File: tb/tb_clock_display_scanner.sv
// Directed table-driven bench for clock_display_scanner (REFRESH_DIV=4, BLANK_CYCLES=2).
module tb_clock_display_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] digits_in = '0;
    logic [5:0]  dp_in = '0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [5:0]  an_n;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;
    int cur_t  = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] EXP_D5_ZERO = 7'h7F;
`else
    localparam logic [6:0] EXP_D5_ZERO = 7'b1000000;
`endif

    clock_display_scanner #(.REFRESH_DIV(4), .BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [23:0] dig;
        logic [5:0]  dp;
        int          t;
        logic [5:0]  an;
        logic [6:0]  seg;
        logic        dpn;
        logic        ft;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [5:0] an, input logic [6:0] seg,
                             input logic dpn, input logic ft);
        check({name, ".an_n"}, 32'(an_n), 32'(an));
        check({name, ".seg_n"}, 32'(seg_n), 32'(seg));
        check({name, ".dp_n"}, 32'(dp_n), 32'(dpn));
        check({name, ".frame_tick"}, 32'(frame_tick), 32'(ft));
    endtask

    // Reset sampled on two edges; on return cur_t=0 is the first post-reset cycle
    task automatic do_reset(input logic [23:0] d, input logic [5:0] p);
        @(negedge clk);
        reset = 1'b1;
        digits_in = d;
        dp_in = p;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cur_t = 0;
    endtask

    task automatic advance(input int t);
        while (cur_t < t) begin
            @(negedge clk);
            cur_t++;
        end
    endtask

    function automatic vec_t mk(input string n, input logic [23:0] d, input logic [5:0] p,
                                input int t, input logic [5:0] an, input logic [6:0] seg,
                                input logic dpn, input logic ft);
        vec_t v;
        v.name = n; v.dig = d; v.dp = p; v.t = t;
        v.an = an; v.seg = seg; v.dpn = dpn; v.ft = ft;
        return v;
    endfunction

    initial begin
        // Scan of 12:34:59 with dp on digit 2
        vecs.push_back(mk("scan_t0_blank", 24'h123459, 6'b000100, 0,  6'h3F, 7'h7F, 1'b1, 1'b0));
        vecs.push_back(mk("scan_t1_blank", 24'h123459, 6'b000100, 1,  6'h3F, 7'h7F, 1'b1, 1'b0));
        vecs.push_back(mk("scan_d0_first", 24'h123459, 6'b000100, 2,  6'b111110, 7'b0010000, 1'b1, 1'b0));
        vecs.push_back(mk("scan_d0_last",  24'h123459, 6'b000100, 5,  6'b111110, 7'b0010000, 1'b1, 1'b0));
        vecs.push_back(mk("scan_gap01",    24'h123459, 6'b000100, 6,  6'h3F, 7'h7F, 1'b1, 1'b0));
        vecs.push_back(mk("scan_d1",       24'h123459, 6'b000100, 8,  6'b111101, 7'b0010010, 1'b1, 1'b0));
        vecs.push_back(mk("scan_d2_dp",    24'h123459, 6'b000100, 14, 6'b111011, 7'b0011001, 1'b0, 1'b0));
        vecs.push_back(mk("scan_d3",       24'h123459, 6'b000100, 20, 6'b110111, 7'b0110000, 1'b1, 1'b0));
        vecs.push_back(mk("scan_d4",       24'h123459, 6'b000100, 26, 6'b101111, 7'b0100100, 1'b1, 1'b0));
        vecs.push_back(mk("scan_d5",       24'h123459, 6'b000100, 32, 6'b011111, 7'b1111001, 1'b1, 1'b0));
        vecs.push_back(mk("scan_d5_tick",  24'h123459, 6'b000100, 35, 6'b011111, 7'b1111001, 1'b1, 1'b1));
        vecs.push_back(mk("scan_wrap_gap", 24'h123459, 6'b000100, 36, 6'h3F, 7'h7F, 1'b1, 1'b0));
        vecs.push_back(mk("scan_wrap_d0",  24'h123459, 6'b000100, 38, 6'b111110, 7'b0010000, 1'b1, 1'b0));
        // Non-BCD nibble on digit 1 blanks segments but keeps the dp
        vecs.push_back(mk("invalid_d1",    24'h0000A0, 6'b000010, 8,  6'b111101, 7'h7F, 1'b0, 1'b0));
        vecs.push_back(mk("invalid_d0_ok", 24'h0000A0, 6'b000010, 2,  6'b111110, 7'b1000000, 1'b1, 1'b0));
        // Leading zero on digit 5
        vecs.push_back(mk("lz_d0",         24'h012345, 6'b000000, 2,  6'b111110, 7'b0010010, 1'b1, 1'b0));
        vecs.push_back(mk("lz_d5",         24'h012345, 6'b000000, 32, 6'b011111, EXP_D5_ZERO, 1'b1, 1'b0));
        vecs.push_back(mk("lz_d5_dp",      24'h012345, 6'b100000, 33, 6'b011111, EXP_D5_ZERO, 1'b0, 1'b0));

        foreach (vecs[i]) begin
            do_reset(vecs[i].dig, vecs[i].dp);
            advance(vecs[i].t);
            check_out(vecs[i].name, vecs[i].an, vecs[i].seg, vecs[i].dpn, vecs[i].ft);
        end

        // Reset mid-SHOW of digit 3, held for 3 edges
        do_reset(24'h123459, 6'b000000);
        advance(21);
        check_out("pre_reset_d3", 6'b110111, 7'b0110000, 1'b1, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_out("reset_first_edge", 6'h3F, 7'h7F, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_out("reset_held", 6'h3F, 7'h7F, 1'b1, 1'b0);
        reset = 1'b0;
        cur_t = 0;
        check_out("post_reset_t0", 6'h3F, 7'h7F, 1'b1, 1'b0);
        advance(1);
        check_out("post_reset_t1", 6'h3F, 7'h7F, 1'b1, 1'b0);
        advance(2);
        check_out("post_reset_d0", 6'b111110, 7'b0010000, 1'b1, 1'b0);

        // Five frames: anode sequence and a single frame_tick per 36 cycles
        do_reset(24'h123459, 6'b000000);
        for (int t = 0; t < 180; t++) begin
            int p;
            logic [5:0] exp_an;
            advance(t);
            p = t % 36;
            exp_an = ((p % 6) < 2) ? 6'h3F : ~(6'b000001 << (p / 6));
            check($sformatf("frame_an_t%0d", t), 32'(an_n), 32'(exp_an));
            check($sformatf("frame_tick_t%0d", t), 32'(frame_tick), 32'(p == 35));
        end

        // Snapshot holds through the frame despite input change while digit 2 is lit
        do_reset(24'h123459, 6'b000100);
        advance(14);
        check_out("snap_d2", 6'b111011, 7'b0011001, 1'b0, 1'b0);
        digits_in = 24'h000000;
        dp_in = 6'b000000;
        advance(20);
        check_out("snap_d3_held", 6'b110111, 7'b0110000, 1'b1, 1'b0);
        advance(26);
        check_out("snap_d4_held", 6'b101111, 7'b0100100, 1'b1, 1'b0);
        advance(32);
        check_out("snap_d5_held", 6'b011111, 7'b1111001, 1'b1, 1'b0);
        advance(38);
        check_out("snap_new_d0", 6'b111110, 7'b1000000, 1'b1, 1'b0);
        advance(50);
        check_out("snap_new_d2", 6'b111011, 7'b1000000, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
